// File: rtl/pixel_color_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pixel_color_scheduler
// Description : Feeds per-pixel hit records into a fixed-latency, non-stallable
//               shading pipeline and re-pairs each returned colour with its
//               pixel through a tag delay line. Results are queued in a
//               first-word-fall-through FIFO for the frame-buffer writer.
//               Credit throttling (FIFO entries + in-flight records) keeps the
//               FIFO from overflowing even though the shader cannot stall.
// Ports       :
//   clk_in, rst_in (async, active-low)
//   hit_*_in / hit_ready_out   : hit record from the ray caster (valid/ready)
//   shade_*_out                : registered record issued to the shader
//   shade_r/g/b_in, shade_valid_in : shader result, SHADE_LATENCY cycles later
//   pix_*_out / pix_ready_in   : pixel stream to the frame-buffer writer
//   busy_out                   : work in flight or queued
//   sync_err_out               : sticky tag/return mismatch flag
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_color_scheduler #(
    parameter int          SHADE_LATENCY = 32,
    parameter int          OUT_DEPTH     = 8,
    parameter logic [31:0] BG_COLOR      = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    // hit record input
    input  logic        hit_valid_in,
    output logic        hit_ready_out,
    input  logic        hit_miss_in,
    input  logic [10:0] hit_x_in,
    input  logic [9:0]  hit_y_in,
    input  logic [31:0] hit_block_pos_x_in,
    input  logic [31:0] hit_block_pos_y_in,
    input  logic [31:0] hit_block_pos_z_in,
    input  logic [2:0]  hit_block_color_in,
    input  logic [2:0]  hit_block_dir_in,
    input  logic [31:0] hit_ray_x_in,
    input  logic [31:0] hit_ray_y_in,
    input  logic [31:0] hit_ray_z_in,
    input  logic [31:0] hit_t_in,
    // issue to shader
    output logic        shade_valid_out,
    output logic [31:0] shade_block_pos_x_out,
    output logic [31:0] shade_block_pos_y_out,
    output logic [31:0] shade_block_pos_z_out,
    output logic [2:0]  shade_block_color_out,
    output logic [2:0]  shade_block_dir_out,
    output logic [31:0] shade_ray_x_out,
    output logic [31:0] shade_ray_y_out,
    output logic [31:0] shade_ray_z_out,
    output logic [31:0] shade_t_out,
    // shader return
    input  logic [31:0] shade_r_in,
    input  logic [31:0] shade_g_in,
    input  logic [31:0] shade_b_in,
    input  logic        shade_valid_in,
    // pixel output
    output logic        pix_valid_out,
    input  logic        pix_ready_in,
    output logic [10:0] pix_x_out,
    output logic [9:0]  pix_y_out,
    output logic [31:0] pix_r_out,
    output logic [31:0] pix_g_out,
    output logic [31:0] pix_b_out,
    // status
    output logic        busy_out,
    output logic        sync_err_out
);

    localparam int c_cnt_w = $clog2(OUT_DEPTH + 1);
    localparam int c_ptr_w = $clog2(OUT_DEPTH);
    localparam int c_drn_w = $clog2(SHADE_LATENCY + 2);
    localparam int c_tag_w = 23;   // {x[10:0], y[9:0], miss, valid}

    localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(OUT_DEPTH);
    localparam logic [c_drn_w-1:0] c_drn_last = c_drn_w'(SHADE_LATENCY);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(OUT_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_drn_w-1:0]   r_drn_cnt;

    logic [c_cnt_w-1:0]   r_inflight;
    logic [c_cnt_w-1:0]   r_fifo_cnt;
    logic [c_cnt_w:0]     w_used;

    logic                 r_iss_vld;
    logic                 r_iss_miss;
    logic [10:0]          r_iss_x;
    logic [9:0]           r_iss_y;

    logic [c_tag_w-1:0]   r_tag [SHADE_LATENCY];
    logic [c_tag_w-1:0]   w_tail;
    logic                 w_ret;
    logic                 w_ret_miss;
    logic [10:0]          w_ret_x;
    logic [9:0]           w_ret_y;

    logic [10:0]          r_mem_x [OUT_DEPTH];
    logic [9:0]           r_mem_y [OUT_DEPTH];
    logic [31:0]          r_mem_r [OUT_DEPTH];
    logic [31:0]          r_mem_g [OUT_DEPTH];
    logic [31:0]          r_mem_b [OUT_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;

    logic                 r_sync_err;
    logic                 w_run;
    logic                 w_accept;
    logic                 w_pop;

    // ------------------------------------------------------------------
    // Control FSM: after reset, wait long enough for every result issued
    // before reset to have left the shader before accepting new work.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_DRAIN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DRAIN: if (r_drn_cnt == c_drn_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_DRAIN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_drn_cnt <= '0;
        end else if (r_state == ST_DRAIN && r_drn_cnt != c_drn_last) begin
            r_drn_cnt <= r_drn_cnt + c_drn_w'(1);
        end
    end

    assign w_run = (r_state == ST_RUN);

    // ------------------------------------------------------------------
    // Credits: only registered counts feed the ready, so a pop frees its
    // slot one cycle later and pix_ready_in never reaches hit_ready_out.
    // ------------------------------------------------------------------
    assign w_used        = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
    assign hit_ready_out = w_run && (w_used < c_depth);
    assign w_accept      = hit_valid_in & hit_ready_out;
    assign w_pop         = pix_valid_out & pix_ready_in;

    // ------------------------------------------------------------------
    // Issue register. Miss records take a slot in the tag line but are not
    // shown to the shader; the shade fields hold when nothing is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shade_valid_out       <= 1'b0;
            r_iss_vld             <= 1'b0;
            r_iss_miss            <= 1'b0;
            r_iss_x               <= '0;
            r_iss_y               <= '0;
            shade_block_pos_x_out <= '0;
            shade_block_pos_y_out <= '0;
            shade_block_pos_z_out <= '0;
            shade_block_color_out <= '0;
            shade_block_dir_out   <= '0;
            shade_ray_x_out       <= '0;
            shade_ray_y_out       <= '0;
            shade_ray_z_out       <= '0;
            shade_t_out           <= '0;
        end else begin
            shade_valid_out <= w_accept & ~hit_miss_in;
            r_iss_vld       <= w_accept;
            if (w_accept) begin
                r_iss_miss            <= hit_miss_in;
                r_iss_x               <= hit_x_in;
                r_iss_y               <= hit_y_in;
                shade_block_pos_x_out <= hit_block_pos_x_in;
                shade_block_pos_y_out <= hit_block_pos_y_in;
                shade_block_pos_z_out <= hit_block_pos_z_in;
                shade_block_color_out <= hit_block_color_in;
                shade_block_dir_out   <= hit_block_dir_in;
                shade_ray_x_out       <= hit_ray_x_in;
                shade_ray_y_out       <= hit_ray_y_in;
                shade_ray_z_out       <= hit_ray_z_in;
                shade_t_out           <= hit_t_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag delay line: the tag enters alongside shade_valid_out and emerges
    // in the same cycle as the matching shader result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < SHADE_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= {r_iss_x, r_iss_y, r_iss_miss, r_iss_vld};
            for (int i = 1; i < SHADE_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tail     = r_tag[SHADE_LATENCY-1];
    assign w_ret      = w_tail[0];
    assign w_ret_miss = w_tail[1];
    assign w_ret_y    = w_tail[11:2];
    assign w_ret_x    = w_tail[22:12];

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through). Every emerging tag is written,
    // even if the shader failed to flag its result, so pixel order and the
    // credit accounting stay intact.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem_x[i] <= '0;
                r_mem_y[i] <= '0;
                r_mem_r[i] <= '0;
                r_mem_g[i] <= '0;
                r_mem_b[i] <= '0;
            end
        end else if (w_ret) begin
            r_mem_x[r_wr_ptr] <= w_ret_x;
            r_mem_y[r_wr_ptr] <= w_ret_y;
            r_mem_r[r_wr_ptr] <= w_ret_miss ? BG_COLOR : shade_r_in;
            r_mem_g[r_wr_ptr] <= w_ret_miss ? BG_COLOR : shade_g_in;
            r_mem_b[r_wr_ptr] <= w_ret_miss ? BG_COLOR : shade_b_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_ret) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

    // Accept, return and pop may all land in one cycle; each counter sees
    // only its own increment/decrement pair.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_inflight <= '0;
            r_fifo_cnt <= '0;
        end else begin
            case ({w_accept, w_ret})
                2'b10:   r_inflight <= r_inflight + c_cnt_w'(1);
                2'b01:   r_inflight <= r_inflight - c_cnt_w'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_ret, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_cnt_w'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Shader valid disagreeing with the tag stream; DRAIN returns are stale
    // by definition and are not flagged.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sync_err <= 1'b0;
        end else if (w_run && ((w_ret && !w_ret_miss && !shade_valid_in) ||
                               (shade_valid_in && (!w_ret || w_ret_miss)))) begin
            r_sync_err <= 1'b1;
        end
    end

    assign pix_valid_out = (r_fifo_cnt != '0);
    assign pix_x_out     = r_mem_x[r_rd_ptr];
    assign pix_y_out     = r_mem_y[r_rd_ptr];
    assign pix_r_out     = r_mem_r[r_rd_ptr];
    assign pix_g_out     = r_mem_g[r_rd_ptr];
    assign pix_b_out     = r_mem_b[r_rd_ptr];
    assign busy_out      = (r_inflight != '0) || (r_fifo_cnt != '0);
    assign sync_err_out  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_color_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_color_scheduler
// Description : Self-checking bench for pixel_color_scheduler with a stub
//               fixed-latency shader and a pixel-level reference model
//               (queue of outstanding pixels with their due cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_color_scheduler;

    localparam int          L  = 4;
    localparam int          D  = 4;
    localparam logic [31:0] BG = 32'h00FF00FF;
    localparam int          NEVER = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        hit_valid_in = 1'b0, hit_miss_in = 1'b0;
    logic [10:0] hit_x_in = '0;
    logic [9:0]  hit_y_in = '0;
    logic [31:0] hit_block_pos_x_in = '0, hit_block_pos_y_in = '0, hit_block_pos_z_in = '0;
    logic [2:0]  hit_block_color_in = '0, hit_block_dir_in = '0;
    logic [31:0] hit_ray_x_in = '0, hit_ray_y_in = '0, hit_ray_z_in = '0, hit_t_in = '0;
    logic        pix_ready_in = 1'b1;

    logic        hit_ready_out, shade_valid_out, pix_valid_out, busy_out, sync_err_out;
    logic [31:0] shade_block_pos_x_out, shade_block_pos_y_out, shade_block_pos_z_out;
    logic [2:0]  shade_block_color_out, shade_block_dir_out;
    logic [31:0] shade_ray_x_out, shade_ray_y_out, shade_ray_z_out, shade_t_out;
    logic [10:0] pix_x_out;
    logic [9:0]  pix_y_out;
    logic [31:0] pix_r_out, pix_g_out, pix_b_out;

    // Stub shader: fixed L-cycle pipeline, can be told to drop one valid.
    logic        stub_v [L] = '{default: 1'b0};
    logic [31:0] stub_r [L] = '{default: 32'h0};
    logic [31:0] stub_g [L] = '{default: 32'h0};
    logic [31:0] stub_b [L] = '{default: 32'h0};
    int          drop_req = 0;
    int          drop_ack = 0;

    always @(posedge clk) begin
        if (shade_valid_out && (drop_req != drop_ack)) begin
            stub_v[0] <= 1'b0;
            drop_ack  <= drop_ack + 1;
        end else begin
            stub_v[0] <= shade_valid_out;
        end
        stub_r[0] <= shade_block_pos_x_out ^ shade_block_pos_y_out ^ shade_block_pos_z_out;
        stub_g[0] <= shade_ray_x_out ^ shade_ray_y_out ^ shade_ray_z_out;
        stub_b[0] <= shade_t_out ^ {26'h0, shade_block_dir_out, shade_block_color_out};
        for (int i = 1; i < L; i++) begin
            stub_v[i] <= stub_v[i-1];
            stub_r[i] <= stub_r[i-1];
            stub_g[i] <= stub_g[i-1];
            stub_b[i] <= stub_b[i-1];
        end
    end

    pixel_color_scheduler #(
        .SHADE_LATENCY (L),
        .OUT_DEPTH     (D),
        .BG_COLOR      (BG)
    ) dut (
        .clk_in                (clk),
        .rst_in                (rst_n),
        .hit_valid_in          (hit_valid_in),
        .hit_ready_out         (hit_ready_out),
        .hit_miss_in           (hit_miss_in),
        .hit_x_in              (hit_x_in),
        .hit_y_in              (hit_y_in),
        .hit_block_pos_x_in    (hit_block_pos_x_in),
        .hit_block_pos_y_in    (hit_block_pos_y_in),
        .hit_block_pos_z_in    (hit_block_pos_z_in),
        .hit_block_color_in    (hit_block_color_in),
        .hit_block_dir_in      (hit_block_dir_in),
        .hit_ray_x_in          (hit_ray_x_in),
        .hit_ray_y_in          (hit_ray_y_in),
        .hit_ray_z_in          (hit_ray_z_in),
        .hit_t_in              (hit_t_in),
        .shade_valid_out       (shade_valid_out),
        .shade_block_pos_x_out (shade_block_pos_x_out),
        .shade_block_pos_y_out (shade_block_pos_y_out),
        .shade_block_pos_z_out (shade_block_pos_z_out),
        .shade_block_color_out (shade_block_color_out),
        .shade_block_dir_out   (shade_block_dir_out),
        .shade_ray_x_out       (shade_ray_x_out),
        .shade_ray_y_out       (shade_ray_y_out),
        .shade_ray_z_out       (shade_ray_z_out),
        .shade_t_out           (shade_t_out),
        .shade_r_in            (stub_r[L-1]),
        .shade_g_in            (stub_g[L-1]),
        .shade_b_in            (stub_b[L-1]),
        .shade_valid_in        (stub_v[L-1]),
        .pix_valid_out         (pix_valid_out),
        .pix_ready_in          (pix_ready_in),
        .pix_x_out             (pix_x_out),
        .pix_y_out             (pix_y_out),
        .pix_r_out             (pix_r_out),
        .pix_g_out             (pix_g_out),
        .pix_b_out             (pix_b_out),
        .busy_out              (busy_out),
        .sync_err_out          (sync_err_out)
    );

    // Reference model: every accepted pixel is outstanding until popped and
    // becomes visible L+2 cycles after the cycle it was accepted in.
    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [31:0] r, g, b;
        int          due;
    } pix_t;

    pix_t q[$];
    int   now       = 0;
    int   since_rel = 0;
    bit   in_rst    = 1'b1;
    logic exp_sv    = 1'b0;
    int   err_due   = NEVER;
    bit   drop_arm  = 1'b0;
    int   n_vec     = 0;
    int   n_err     = 0;
    bit   a;
    int   first, lat, n_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, update the model with
    // this cycle's accept/pop, then step past the rising edge.
    task automatic cycle(output bit acc);
        bit   exp_ready, exp_pv, pend_drop;
        pix_t e;
        @(negedge clk);
        exp_ready = !in_rst && (since_rel >= L + 1) && (q.size() < D);
        exp_pv    = (q.size() > 0) && (q[0].due <= now);
        chk("hit_ready",   64'(hit_ready_out),   64'(exp_ready));
        chk("pix_valid",   64'(pix_valid_out),   64'(exp_pv));
        chk("shade_valid", 64'(shade_valid_out), 64'(exp_sv));
        chk("busy",        64'(busy_out),        64'(q.size() != 0));
        chk("sync_err",    64'(sync_err_out),    64'(now >= err_due));
        if (exp_pv && pix_ready_in) begin
            chk("pix_x", 64'(pix_x_out), 64'(q[0].x));
            chk("pix_y", 64'(pix_y_out), 64'(q[0].y));
            chk("pix_r", 64'(pix_r_out), 64'(q[0].r));
            chk("pix_g", 64'(pix_g_out), 64'(q[0].g));
            chk("pix_b", 64'(pix_b_out), 64'(q[0].b));
            void'(q.pop_front());
        end
        acc       = hit_valid_in && exp_ready;
        pend_drop = 1'b0;
        if (acc) begin
            e.x   = hit_x_in;
            e.y   = hit_y_in;
            e.r   = hit_miss_in ? BG : (hit_block_pos_x_in ^ hit_block_pos_y_in ^ hit_block_pos_z_in);
            e.g   = hit_miss_in ? BG : (hit_ray_x_in ^ hit_ray_y_in ^ hit_ray_z_in);
            e.b   = hit_miss_in ? BG : (hit_t_in ^ {26'h0, hit_block_dir_in, hit_block_color_in});
            e.due = now + L + 2;
            q.push_back(e);
            if (drop_arm && !hit_miss_in) begin
                err_due   = now + L + 2;
                pend_drop = 1'b1;
                drop_arm  = 1'b0;
            end
        end
        exp_sv = acc && !hit_miss_in;
        @(posedge clk);
        #1;
        now++;
        if (!in_rst) since_rel++;
        if (pend_drop) drop_req++;
    endtask

    task automatic set_hit(input bit v, input bit miss, input logic [10:0] x, input logic [9:0] y);
        hit_valid_in       = v;
        hit_miss_in        = miss;
        hit_x_in           = x;
        hit_y_in           = y;
        hit_block_pos_x_in = $urandom;
        hit_block_pos_y_in = $urandom;
        hit_block_pos_z_in = $urandom;
        hit_block_color_in = 3'($urandom);
        hit_block_dir_in   = 3'($urandom);
        hit_ray_x_in       = $urandom;
        hit_ray_y_in       = $urandom;
        hit_ray_z_in       = $urandom;
        hit_t_in           = $urandom;
    endtask

    task automatic send(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) cycle(ok);
        chk(tag, 64'(ok), 64'(1));
    endtask

    task automatic idle(input int n);
        bit dummy;
        hit_valid_in = 1'b0;
        repeat (n) cycle(dummy);
    endtask

    task automatic do_reset(input int ncyc);
        bit dummy;
        rst_n   = 1'b0;
        in_rst  = 1'b1;
        q.delete();
        exp_sv  = 1'b0;
        err_due = NEVER;
        #1;
        chk("rst_pix_valid", 64'(pix_valid_out),         64'(0));
        chk("rst_pix_r",     64'(pix_r_out),             64'(0));
        chk("rst_pix_x",     64'(pix_x_out),             64'(0));
        chk("rst_shade_pos", 64'(shade_block_pos_x_out), 64'(0));
        chk("rst_ready",     64'(hit_ready_out),         64'(0));
        chk("rst_busy",      64'(busy_out),              64'(0));
        chk("rst_sync_err",  64'(sync_err_out),          64'(0));
        repeat (ncyc) cycle(dummy);
        rst_n     = 1'b1;
        in_rst    = 1'b0;
        since_rel = 0;
    endtask

    initial begin
        #2;
        do_reset(3);

        // Drain window with a held request: first accept on cycle L+2.
        set_hit(1'b1, 1'b0, 11'd100, 10'd50);
        hit_block_pos_x_in = 32'h3F800000;
        hit_block_pos_y_in = 32'h0;
        hit_block_pos_z_in = 32'h0;
        first = 0;
        for (int c = 1; c <= 20 && first == 0; c++) begin
            cycle(a);
            if (a) first = c;
        end
        hit_valid_in = 1'b0;
        chk("first_accept_cycle", 64'(first), 64'(L + 2));

        // Single hit latency and contents.
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (pix_valid_out) begin
                lat = c;
                chk("single_x", 64'(pix_x_out), 64'(100));
                chk("single_y", 64'(pix_y_out), 64'(50));
                chk("single_r", 64'(pix_r_out), 64'(32'h3F800000));
            end
            cycle(a);
        end
        chk("single_latency", 64'(lat), 64'(L + 2));
        idle(4);

        // Miss followed by a hit: background colour, order kept.
        set_hit(1'b1, 1'b1, 11'd7, 10'd3);
        send("miss_accept");
        set_hit(1'b1, 1'b0, 11'd8, 10'd3);
        send("hit_after_miss_accept");
        idle(L + 6);

        // Back-pressure: only D credits while the consumer stalls.
        pix_ready_in = 1'b0;
        n_acc = 0;
        set_hit(1'b1, 1'b0, 11'(200), 10'(0));
        for (int c = 0; c < 20; c++) begin
            cycle(a);
            if (a) begin
                n_acc++;
                set_hit(n_acc < 10, 1'b0, 11'(200 + n_acc), 10'(n_acc));
            end
        end
        chk("bp_accepted", 64'(n_acc), 64'(D));
        chk("bp_ready_low", 64'(hit_ready_out), 64'(0));
        pix_ready_in = 1'b1;
        for (int c = 0; c < 200 && n_acc < 10; c++) begin
            cycle(a);
            if (a) begin
                n_acc++;
                set_hit(n_acc < 10, 1'b0, 11'(200 + n_acc), 10'(n_acc));
            end
        end
        chk("bp_total", 64'(n_acc), 64'(10));
        idle(L + D + 6);
        chk("bp_sync_err", 64'(sync_err_out), 64'(0));

        // Randomized traffic with random consumer stalls.
        for (int c = 0; c < 400; c++) begin
            set_hit($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    11'($urandom), 10'($urandom));
            pix_ready_in = $urandom_range(0, 3) != 0;
            cycle(a);
        end
        pix_ready_in = 1'b1;
        idle(L + D + 6);
        chk("rand_sync_err", 64'(sync_err_out), 64'(0));

        // Shader loses one valid for a hit pixel: sticky sync error.
        drop_arm = 1'b1;
        set_hit(1'b1, 1'b0, 11'd300, 10'd30);
        send("drop_accept");
        idle(L + 6);
        chk("sync_err_set", 64'(sync_err_out), 64'(1));
        for (int c = 0; c < 30; c++) begin
            set_hit($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
                    11'($urandom), 10'($urandom));
            cycle(a);
        end
        idle(L + D + 6);
        chk("sync_err_sticky", 64'(sync_err_out), 64'(1));

        // Reset with three pixels in flight; stale returns must vanish.
        set_hit(1'b1, 1'b0, 11'd1, 10'd1);
        send("stale_accept0");
        set_hit(1'b1, 1'b0, 11'd2, 10'd1);
        send("stale_accept1");
        set_hit(1'b1, 1'b0, 11'd3, 10'd1);
        send("stale_accept2");
        idle(1);
        do_reset(2);
        idle(L + 8);
        chk("stale_pix_valid", 64'(pix_valid_out), 64'(0));
        chk("stale_busy",      64'(busy_out),      64'(0));
        chk("stale_sync_err",  64'(sync_err_out),  64'(0));

        // Still functional afterwards.
        set_hit(1'b1, 1'b0, 11'd400, 10'd40);
        send("post_reset_accept");
        idle(L + 6);
        chk("post_reset_idle", 64'(busy_out), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
